// File: rtl/rmc_pkg.sv
// Shared types and constants for the row-matrix scheduler: state encoding,
// DSP pipeline timing constants and counter width helpers.
package rmc_pkg;

  typedef logic [1:0] rmc_state_t;

  localparam rmc_state_t ST_IDLE   = 2'd0;
  localparam rmc_state_t ST_ISSUE  = 2'd1;
  localparam rmc_state_t ST_DRAIN  = 2'd2;
  localparam rmc_state_t ST_RESULT = 2'd3;

  // Accepted beat reaches the accumulator this many cycles after acceptance;
  // the finished row is captured one cycle after that.
  localparam int DSP_ACC_STAGE   = 3;
  localparam int RES_CAPTURE_LAT = 4;

  // Width needed to hold a count 0..max_val
  function automatic int rmc_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // Width needed to index 0..n-1, never narrower than one bit
  function automatic int rmc_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rmc_tag_pipe.sv
// Accept / first-beat shift register aligning accumulate enables with the
// DSP lane pipeline; reports empty once no accepted beat is in flight.
module rmc_tag_pipe
  import rmc_pkg::*;
#(
  parameter int STAGES = DSP_ACC_STAGE
)(
  input  logic CLK,
  input  logic RSTN,
  input  logic accept,
  input  logic first_beat,
  output logic acc_en,
  output logic acc_clr,
  output logic empty
);

  logic [STAGES-1:0] vld_sr;
  logic [STAGES-1:0] first_sr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_sr   <= '0;
      first_sr <= '0;
    end else begin
      vld_sr   <= {vld_sr[STAGES-2:0], accept};
      first_sr <= {first_sr[STAGES-2:0], accept && first_beat};
    end
  end

  assign acc_en  = vld_sr[STAGES-1];
  assign acc_clr = vld_sr[STAGES-1] && first_sr[STAGES-1];
  assign empty   = ~|vld_sr;

endmodule

// File: rtl/rmc_row_scheduler.sv
// Multi-row scheduler: streams OP1, drives weight BRAM reads and DSP lane
// enables, returns each finished row. RMC_PERF_CNT_EN adds PERF_STALL/PERF_BP.
module rmc_row_scheduler
  import rmc_pkg::*;
#(
  parameter int OP1_ROW      = 4,
  parameter int WEIGHT_ROW   = 4,
  parameter int WEIGHT_COL   = 8,
  parameter int OP1_WIDTH    = 8,
  parameter int DSPOUT_WIDTH = 8,
  parameter int BRAM_DEPTH   = 64,
  localparam int NW = rmc_cnt_w(OP1_ROW),
  localparam int KW = rmc_cnt_w(WEIGHT_ROW),
  localparam int RW = rmc_idx_w(OP1_ROW),
  localparam int AW = rmc_idx_w(BRAM_DEPTH),
  localparam int DW = DSPOUT_WIDTH * WEIGHT_COL
)(
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 START,
  input  logic [NW-1:0]        N_ROWS,
  input  logic [KW-1:0]        K_LEN,
  // OP1 and result ports: a transfer happens on the rising edge where
  // VALID && READY are both high; VALID never depends on READY.
  input  logic [OP1_WIDTH-1:0] OP1_IN,
  input  logic                 OP1_IN_VALID,
  output logic                 OP1_IN_READY,
  output logic [AW-1:0]        BRAM_ADDR,
  output logic                 BRAM_RD_EN,
  output logic [OP1_WIDTH-1:0] OP1_OUT,
  output logic                 DSP_EN,
  output logic                 DSP_ACC_EN,
  output logic                 DSP_ACC_CLR,
  input  logic [DW-1:0]        DSP_OUT,
  output logic [DW-1:0]        RES_DATA,
  output logic [RW-1:0]        RES_ROW,
  output logic                 RES_LAST,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic                 BUSY,
  output logic                 DONE,
`ifdef RMC_PERF_CNT_EN
  output logic [31:0]          PERF_STALL,
  output logic [31:0]          PERF_BP,
`endif
  output rmc_state_t           DBG_STATE
);

  generate
    if (WEIGHT_ROW > BRAM_DEPTH) begin : g_bad_depth
      $error("rmc_row_scheduler: WEIGHT_ROW must not exceed BRAM_DEPTH");
    end
  endgenerate

  rmc_state_t           state_q, state_d;
  logic [NW-1:0]        n_rows_q;
  logic [KW-1:0]        k_len_q;
  logic [KW-1:0]        k_q;
  logic [RW-1:0]        row_q;
  logic [RW-1:0]        res_row_q;
  logic [OP1_WIDTH-1:0] op1_out_q;
  logic [DW-1:0]        res_data_q;
  logic                 res_last_q;
  logic                 done_q;
  logic                 start_acc;
  logic                 zero_job;
  logic                 accept;
  logic                 k_last;
  logic                 row_last;
  logic                 tag_acc_en;
  logic                 tag_acc_clr;
  logic                 tag_empty;

  assign start_acc = (state_q == ST_IDLE) && START;
  assign zero_job  = (N_ROWS == '0) || (K_LEN == '0);
  assign accept    = (state_q == ST_ISSUE) && OP1_IN_VALID;
  assign k_last    = (k_q + KW'(1)) == k_len_q;
  assign row_last  = (NW'(row_q) + NW'(1)) == n_rows_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (START && !zero_job) state_d = ST_ISSUE;
      ST_ISSUE:  if (accept && k_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (tag_empty) state_d = ST_RESULT;
      ST_RESULT: if (RES_READY) state_d = row_last ? ST_IDLE : ST_ISSUE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      n_rows_q   <= '0;
      k_len_q    <= '0;
      k_q        <= '0;
      row_q      <= '0;
      res_row_q  <= '0;
      op1_out_q  <= '0;
      res_data_q <= '0;
      res_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (start_acc) begin
        n_rows_q <= N_ROWS;
        k_len_q  <= K_LEN;
        row_q    <= '0;
        k_q      <= '0;
        // An empty job never leaves IDLE but still reports completion
        if (zero_job) done_q <= 1'b1;
      end
      if (accept) begin
        op1_out_q <= OP1_IN;
        k_q       <= k_last ? '0 : k_q + KW'(1);
      end
      if (state_q == ST_DRAIN && tag_empty) begin
        res_data_q <= DSP_OUT;
        res_row_q  <= row_q;
        res_last_q <= row_last;
      end
      if (state_q == ST_RESULT && RES_READY) begin
        if (row_last) done_q <= 1'b1;
        else          row_q  <= row_q + RW'(1);
      end
    end
  end

  rmc_tag_pipe #(
    .STAGES(DSP_ACC_STAGE)
  ) u_tag_pipe (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .accept    (accept),
    .first_beat(k_q == '0),
    .acc_en    (tag_acc_en),
    .acc_clr   (tag_acc_clr),
    .empty     (tag_empty)
  );

  assign OP1_IN_READY = (state_q == ST_ISSUE);
  assign BRAM_ADDR    = AW'(k_q);
  assign BRAM_RD_EN   = accept;
  assign OP1_OUT      = op1_out_q;
  assign DSP_EN       = (state_q != ST_IDLE);
  assign DSP_ACC_EN   = tag_acc_en;
  assign DSP_ACC_CLR  = tag_acc_clr;
  assign RES_DATA     = res_data_q;
  assign RES_ROW      = res_row_q;
  assign RES_LAST     = res_last_q;
  assign RES_VALID    = (state_q == ST_RESULT);
  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = done_q;
  assign DBG_STATE    = state_q;

`ifdef RMC_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_bp_q;

  // Both counters saturate rather than wrap
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else if (start_acc) begin
      perf_stall_q <= '0;
      perf_bp_q    <= '0;
    end else begin
      if (state_q == ST_ISSUE && !OP1_IN_VALID && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (state_q == ST_RESULT && !RES_READY && perf_bp_q != '1)
        perf_bp_q <= perf_bp_q + 32'd1;
    end
  end

  assign PERF_STALL = perf_stall_q;
  assign PERF_BP    = perf_bp_q;
`endif

endmodule

// File: tb/tb_rmc_row_scheduler.sv
// Directed bench for rmc_row_scheduler with a weight BRAM and 3-stage DSP
// lane model; expected rows are hand-computed constants.
module tb_rmc_row_scheduler;

  logic        CLK;
  logic        RSTN;
  logic        START;
  logic [2:0]  N_ROWS;
  logic [2:0]  K_LEN;
  logic [7:0]  OP1_IN;
  logic        OP1_IN_VALID;
  logic        OP1_IN_READY;
  logic [5:0]  BRAM_ADDR;
  logic        BRAM_RD_EN;
  logic [7:0]  OP1_OUT;
  logic        DSP_EN;
  logic        DSP_ACC_EN;
  logic        DSP_ACC_CLR;
  logic [63:0] DSP_OUT;
  logic [63:0] RES_DATA;
  logic [1:0]  RES_ROW;
  logic        RES_LAST;
  logic        RES_VALID;
  logic        RES_READY;
  logic        BUSY;
  logic        DONE;
  logic [1:0]  DBG_STATE;
`ifdef RMC_PERF_CNT_EN
  logic [31:0] PERF_STALL;
  logic [31:0] PERF_BP;
`endif

  rmc_row_scheduler dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .N_ROWS(N_ROWS), .K_LEN(K_LEN),
    .OP1_IN(OP1_IN), .OP1_IN_VALID(OP1_IN_VALID), .OP1_IN_READY(OP1_IN_READY),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_RD_EN(BRAM_RD_EN), .OP1_OUT(OP1_OUT),
    .DSP_EN(DSP_EN), .DSP_ACC_EN(DSP_ACC_EN), .DSP_ACC_CLR(DSP_ACC_CLR),
    .DSP_OUT(DSP_OUT), .RES_DATA(RES_DATA), .RES_ROW(RES_ROW),
    .RES_LAST(RES_LAST), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .BUSY(BUSY), .DONE(DONE),
`ifdef RMC_PERF_CNT_EN
    .PERF_STALL(PERF_STALL), .PERF_BP(PERF_BP),
`endif
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- environment: BRAM + DSP lanes ----------------
  logic [63:0]        weight_mem [4];
  logic [63:0]        bram_q;
  logic signed [15:0] m1 [8];
  logic signed [15:0] m2 [8];
  logic [7:0]         acc [8];

  always @(posedge CLK) begin
    if (BRAM_RD_EN) bram_q <= weight_mem[BRAM_ADDR[1:0]];
    if (DSP_EN) begin
      for (int j = 0; j < 8; j++) begin
        m1[j] <= $signed(OP1_OUT) * $signed(bram_q[8*j +: 8]);
        m2[j] <= m1[j];
        if (DSP_ACC_EN) acc[j] <= DSP_ACC_CLR ? m2[j][7:0] : acc[j] + m2[j][7:0];
      end
    end
  end

  always_comb begin
    DSP_OUT = '0;
    for (int j = 0; j < 8; j++) DSP_OUT[8*j +: 8] = acc[j];
  end

  // ---------------- monitors ----------------
  int rd_cnt = 0, acc_cnt = 0, clr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int t_last = 0;
  int rd0, acc0, clr0, done0, busy0;

  always @(negedge CLK) begin
    rd_cnt   += int'(BRAM_RD_EN);
    acc_cnt  += int'(DSP_ACC_EN);
    clr_cnt  += int'(DSP_ACC_CLR);
    done_cnt += int'(DONE);
    busy_cnt += int'(BUSY);
    if (OP1_IN_VALID && OP1_IN_READY) t_last = cyc;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // ---------------- driver tasks (entered and left at posedge+#1) ----------------
  task automatic snap();
    rd0 = rd_cnt; acc0 = acc_cnt; clr0 = clr_cnt; done0 = done_cnt; busy0 = busy_cnt;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic start_job(input logic [2:0] n, input logic [2:0] k);
    START = 1'b1; N_ROWS = n; K_LEN = k;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send_row(input int k_len, input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3, input bit bubbles);
    logic [7:0] vals [4];
    int guard;
    vals = '{v0, v1, v2, v3};
    for (int i = 0; i < k_len; i++) begin
      if (bubbles && i > 0) begin
        OP1_IN_VALID = 1'b0;
        @(posedge CLK); #1;
      end
      OP1_IN_VALID = 1'b1;
      OP1_IN = vals[i];
      guard = 0;
      @(negedge CLK);
      while (!OP1_IN_READY && guard < 50) begin @(negedge CLK); guard++; end
      if (guard >= 50) begin
        check_val("issue_timeout", 64'(OP1_IN_READY), 64'd1);
        OP1_IN_VALID = 1'b0;
        return;
      end
      check_val("bram_addr", 64'(BRAM_ADDR), 64'(i));
      check_val("bram_rd_en", 64'(BRAM_RD_EN), 64'd1);
      @(posedge CLK); #1;
    end
    OP1_IN_VALID = 1'b0;
  endtask

  task automatic take_result(input logic [1:0] exp_row, input bit exp_last, input int bp);
    logic [63:0] exp_d;
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!RES_VALID && guard < 50) begin @(negedge CLK); guard++; end
    check_val("res_valid_timeout", 64'(RES_VALID), 64'd1);
    check_val("res_latency", 64'(cyc - t_last), 64'd5);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 64'(exp_q.size()), 64'd1);
      exp_d = '0;
    end else begin
      exp_d = exp_q.pop_front();
    end
    check_val("res_data", RES_DATA, exp_d);
    check_val("res_row", 64'(RES_ROW), 64'(exp_row));
    check_val("res_last", 64'(RES_LAST), 64'(exp_last));
    repeat (bp) begin
      @(negedge CLK);
      check_val("bp_valid", 64'(RES_VALID), 64'd1);
      check_val("bp_data", RES_DATA, exp_d);
      check_val("bp_row", 64'(RES_ROW), 64'(exp_row));
    end
    @(posedge CLK); #1;
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
  endtask

  task automatic load_basic_weights();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) weight_mem[k][8*j +: 8] = 8'(j + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RSTN = 1'b0; START = 1'b0; N_ROWS = '0; K_LEN = '0;
    OP1_IN = '0; OP1_IN_VALID = 1'b0; RES_READY = 1'b0;
    bram_q = '0;
    for (int j = 0; j < 8; j++) begin m1[j] = '0; m2[j] = '0; acc[j] = '0; end
    load_basic_weights();

    // Reset state
    repeat (3) @(negedge CLK);
    check_val("rst_busy", 64'(BUSY), 64'd0);
    check_val("rst_done", 64'(DONE), 64'd0);
    check_val("rst_ready", 64'(OP1_IN_READY), 64'd0);
    check_val("rst_res_valid", 64'(RES_VALID), 64'd0);
    check_val("rst_dsp_en", 64'(DSP_EN), 64'd0);
    check_val("rst_acc_en", 64'(DSP_ACC_EN), 64'd0);
    check_val("rst_res_data", RES_DATA, 64'd0);
    check_val("rst_op1_out", 64'(OP1_OUT), 64'd0);
    check_val("rst_bram_addr", 64'(BRAM_ADDR), 64'd0);
    check_val("rst_state", 64'(DBG_STATE), 64'd0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    idle_cycles(2);

    // Basic row: lanes 10*(j+1)
    snap();
    exp_q.push_back(64'h5046_3C32_281E_140A);
    start_job(3'd1, 3'd4);
    check_val("issue_busy", 64'(BUSY), 64'd1);
    send_row(4, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    take_result(2'd0, 1'b1, 0);
    idle_cycles(3);
    check_val("basic_rd_cnt", 64'(rd_cnt - rd0), 64'd4);
    check_val("basic_acc_cnt", 64'(acc_cnt - acc0), 64'd4);
    check_val("basic_clr_cnt", 64'(clr_cnt - clr0), 64'd1);
    check_val("basic_done_cnt", 64'(done_cnt - done0), 64'd1);
    check_val("basic_idle", 64'(BUSY), 64'd0);

    // Same row with bubbles between beats
    snap();
    exp_q.push_back(64'h5046_3C32_281E_140A);
    start_job(3'd1, 3'd4);
    send_row(4, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    take_result(2'd0, 1'b1, 0);
    idle_cycles(3);
    check_val("bub_rd_cnt", 64'(rd_cnt - rd0), 64'd4);
    check_val("bub_acc_cnt", 64'(acc_cnt - acc0), 64'd4);
    check_val("bub_done_cnt", 64'(done_cnt - done0), 64'd1);

    // Three rows with back-pressure; weight k=0 lane j = j+1, k=1 lanes = 2
    for (int j = 0; j < 8; j++) weight_mem[1][8*j +: 8] = 8'd2;
    snap();
    exp_q.push_back(64'h0A09_0807_0605_0403);
    exp_q.push_back(64'h100E_0C0A_0806_0402);
    exp_q.push_back(64'hFEFF_0001_0203_0405);
    start_job(3'd3, 3'd2);
    send_row(2, 8'd1, 8'd1, 8'd0, 8'd0, 1'b0);
    take_result(2'd0, 1'b0, 5);
    send_row(2, 8'd2, 8'd0, 8'd0, 8'd0, 1'b0);
    take_result(2'd1, 1'b0, 5);
    send_row(2, 8'hFF, 8'd3, 8'd0, 8'd0, 1'b0);
    take_result(2'd2, 1'b1, 5);
    idle_cycles(3);
    check_val("multi_acc_cnt", 64'(acc_cnt - acc0), 64'd6);
    check_val("multi_clr_cnt", 64'(clr_cnt - clr0), 64'd3);
    check_val("multi_done_cnt", 64'(done_cnt - done0), 64'd1);

    // Degenerate jobs: K_LEN=0 then N_ROWS=0
    snap();
    start_job(3'd1, 3'd0);
    @(negedge CLK);
    check_val("k0_done", 64'(DONE), 64'd1);
    check_val("k0_busy", 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    start_job(3'd0, 3'd3);
    @(negedge CLK);
    check_val("n0_done", 64'(DONE), 64'd1);
    @(posedge CLK); #1;
    idle_cycles(3);
    check_val("degen_done_cnt", 64'(done_cnt - done0), 64'd2);
    check_val("degen_rd_cnt", 64'(rd_cnt - rd0), 64'd0);
    check_val("degen_busy_cnt", 64'(busy_cnt - busy0), 64'd0);

    // Reset while draining a row, then a clean job
    load_basic_weights();
    snap();
    start_job(3'd1, 3'd2);
    send_row(2, 8'd1, 8'd2, 8'd0, 8'd0, 1'b0);
    @(posedge CLK); #1;
    check_val("pre_rst_drain", 64'(DBG_STATE), 64'd2);
    #1 RSTN = 1'b0;
    #1;
    check_val("mid_rst_state", 64'(DBG_STATE), 64'd0);
    check_val("mid_rst_busy", 64'(BUSY), 64'd0);
    check_val("mid_rst_acc_en", 64'(DSP_ACC_EN), 64'd0);
    check_val("mid_rst_acc_clr", 64'(DSP_ACC_CLR), 64'd0);
    check_val("mid_rst_dsp_en", 64'(DSP_EN), 64'd0);
    check_val("mid_rst_res_data", RES_DATA, 64'd0);
    check_val("mid_rst_op1_out", 64'(OP1_OUT), 64'd0);
    idle_cycles(3);
    RSTN = 1'b1;
    idle_cycles(2);
    check_val("mid_rst_no_done", 64'(done_cnt - done0), 64'd0);
    snap();
    exp_q.push_back(64'h5046_3C32_281E_140A);
    start_job(3'd1, 3'd4);
    send_row(4, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    take_result(2'd0, 1'b1, 0);
    idle_cycles(3);
    check_val("post_rst_done_cnt", 64'(done_cnt - done0), 64'd1);

    // Accumulator wrap: 100*2 + 100*2 = 400 -> 0x90 in lane 0
    weight_mem[0] = 64'h2;
    weight_mem[1] = 64'h2;
    exp_q.push_back(64'h0000_0000_0000_0090);
    start_job(3'd1, 3'd2);
    send_row(2, 8'd100, 8'd100, 8'd0, 8'd0, 1'b0);
    take_result(2'd0, 1'b1, 0);
    idle_cycles(2);

    // Final report
    check_val("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rmc_row_scheduler.md
Name: rmc_row_scheduler

Overview:
- Multi-row sequencer for the row-matrix datapath: one weight BRAM (1-cycle read) feeding WEIGHT_COL DSP multiply-accumulate lanes.
- Computes an N_ROWS x K_LEN by K_LEN x WEIGHT_COL product one output row at a time.
- Streams OP1 elements in from upstream with a valid/ready handshake, drives BRAM address, read enable and DSP enables, clears accumulation at each row start, and hands each finished row downstream with valid/ready.
- Restartable after every job; replaces the single-shot controller.

Parameters:
- OP1_ROW, 4, maximum rows per job
- WEIGHT_ROW, 4, maximum accumulation length K
- WEIGHT_COL, 8, DSP lanes
- OP1_WIDTH, 8, signed OP1 element width
- DSPOUT_WIDTH, 8, per-lane accumulator width
- BRAM_DEPTH, 64, weight BRAM depth

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- START  in  1  job start pulse; sampled only in IDLE
- N_ROWS  in  $clog2(OP1_ROW+1)  rows in the job; sampled at START
- K_LEN  in  $clog2(WEIGHT_ROW+1)  terms per row; sampled at START
- OP1_IN  in  OP1_WIDTH  upstream OP1 element
- OP1_IN_VALID  in  1  upstream valid
- OP1_IN_READY  out  1  scheduler accepts an element
- BRAM_ADDR  out  $clog2(BRAM_DEPTH)  weight read address
- BRAM_RD_EN  out  1  weight read enable
- OP1_OUT  out  OP1_WIDTH  OP1 aligned to BRAM data
- DSP_EN  out  1  DSP pipeline enable
- DSP_ACC_EN  out  1  accumulate enable
- DSP_ACC_CLR  out  1  load instead of add (row's first term)
- DSP_OUT  in  DSPOUT_WIDTH*WEIGHT_COL  packed lane accumulators
- RES_DATA  out  DSPOUT_WIDTH*WEIGHT_COL  captured row result
- RES_ROW  out  $clog2(OP1_ROW)  row index of RES_DATA
- RES_LAST  out  1  final row of the job
- RES_VALID  out  1  result valid
- RES_READY  in  1  downstream ready
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse at job end

Behaviour:
- Reset (RSTN=0, asynchronous): state IDLE; all outputs 0, including RES_DATA, OP1_OUT and BRAM_ADDR; counters and tag pipe cleared. A reset mid-job aborts the job with no DONE pulse.
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE
  - On START: latch N_ROWS/K_LEN; row=0, k=0; go to ISSUE.
  - If the latched N_ROWS==0 or K_LEN==0: skip ISSUE; pulse DONE in the next cycle and stay IDLE.
  - START outside IDLE is ignored.
- ISSUE
  - OP1_IN_READY=1.
  - A beat is accepted at cycle t when VALID&&READY. In that cycle: BRAM_ADDR=k (combinational from the counter), BRAM_RD_EN=1, k increments.
  - At the edge ending t, OP1_OUT <= OP1_IN (registered).
  - No VALID means a bubble: no read, k holds.
  - After the beat with k==K_LEN-1, go to DRAIN and clear k.
- Tag pipe: 3-stage shift register of accept flags plus a first-beat flag.
  - DSP_ACC_EN = tag at stage 3, i.e. in cycle t+3.
  - DSP_ACC_CLR = stage-3 tag && first beat of the row.
  - Bubbles never accumulate.
- DSP_EN=1 in every state except IDLE.
- DRAIN
  - Wait until the tag pipe is empty.
  - Capture RES_DATA <= DSP_OUT at the edge ending cycle t_last+4.
  - Go to RESULT. RES_VALID rises in cycle t_last+5.
- RESULT
  - RES_VALID=1; RES_DATA, RES_ROW and RES_LAST are held stable until RES_READY.
  - On the handshake, if row==N_ROWS-1: pulse DONE, go to IDLE. Otherwise row++ and go to ISSUE.
  - Back-pressure from RES_READY only stalls RESULT.
- Arithmetic is done in the DSP lanes: two's complement, wraps modulo 2^DSPOUT_WIDTH. The scheduler never alters data.
- Address wrap cannot occur: K_LEN <= WEIGHT_ROW <= BRAM_DEPTH, checked at elaboration.

Optional Feature:
- RMC_PERF_CNT_EN defined: adds outputs PERF_STALL (32 bits) and PERF_BP (32 bits).
  - PERF_STALL counts ISSUE cycles without OP1_IN_VALID.
  - PERF_BP counts RESULT cycles without RES_READY.
  - Both clear at START and at reset; both saturate at all-ones.
- Undefined: neither port nor the counters exist.

Decomposition:
- Shared package rmc_pkg:
  - state encoding typedef
  - constants DSP_ACC_STAGE=3 and RES_CAPTURE_LAT=4
  - width helper functions for the row/K counters
- One sub-module, rmc_tag_pipe: accept/first-beat shift register producing DSP_ACC_EN and DSP_ACC_CLR, plus an empty flag.

Test Plan:
- Basic row: N_ROWS=1, K_LEN=4, OP1 1,2,3,4 streamed back-to-back, weight row k lane j = j+1. Expect RES_DATA lane j = 10*(j+1), RES_LAST=1, RES_VALID in cycle t_last+5, one DONE pulse.
- Bubbles: same data as the basic row, OP1_IN_VALID low on alternate cycles. Expect an identical result; BRAM_RD_EN count = 4; DSP_ACC_EN count = 4.
- Multi-row with back-pressure: N_ROWS=3, K_LEN=2, rows (1,1), (2,0), (-1,3). RES_READY held low 5 cycles per row. Expect the correct row sums, each held stable; RES_ROW 0,1,2; RES_LAST only on row 2; the second row's accumulation is not contaminated by the first (DSP_ACC_CLR seen per row).
- Degenerate config: START with K_LEN=0. Expect DONE the next cycle, no BRAM_RD_EN, BUSY stays 0.
- Reset mid-job: RSTN low during DRAIN. All outputs 0 immediately; a new START then completes normally.
- Overflow wrap: K_LEN=2, OP1=100,100, weight lane 0 = 2 at DSPOUT_WIDTH=8. Expect lane 0 = 400 mod 256 = 144 (signed -112).
